// File: rtl/uart_frame_tx.sv
// Framed 8N1 UART transmitter: sends HDR0, HDR1, LEN, payload[LEN], CHK on tx.
// Define UART_FRAME_TAIL_EN to append 0x0D 0x0A after CHK.
module uart_frame_tx #(
    parameter int          CLK_FREQ = 50_000_000,
    parameter int          BAUD     = 115200,
    parameter int          MAX_LEN  = 64,
    parameter logic [7:0]  HDR0     = 8'hA5,
    parameter logic [7:0]  HDR1     = 8'h5A
) (
    input  logic       sys_clk,
    input  logic       sys_rstn,
    input  logic       s_frame_start,
    input  logic [7:0] s_frame_len,
    input  logic [7:0] s_byte_data,
    input  logic       s_byte_valid,
    output logic       s_byte_ready,
    output logic       m_busy,
    output logic       m_frame_done,
    output logic       tx
);

    localparam int         DIV       = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int         BW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
`ifdef UART_FRAME_TAIL_EN
        S_TAIL0,
        S_TAIL1,
`endif
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [7:0]    len_q, len_n;
    logic [7:0]    chk_q, chk_n;
    logic [7:0]    cnt_q, cnt_n;
    logic          load;
    logic [7:0]    load_data;

    logic          ser_active;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic [8:0]    shreg;
    logic          last_tick;
    logic          ser_free;

    // Serializer can take a new byte on the final stop-bit cycle, so bytes go out gap-free.
    assign last_tick = ser_active && (bit_cnt == 4'd9) && (baud_cnt == BW'(DIV - 1));
    assign ser_free  = !ser_active || last_tick;

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state <= S_IDLE;
            len_q <= '0;
            chk_q <= '0;
            cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_n;
            len_q <= len_n;
            chk_q <= chk_n;
            cnt_q <= cnt_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n      = state;
        len_n        = len_q;
        chk_n        = chk_q;
        cnt_n        = cnt_q;
        load         = 1'b0;
        load_data    = '0;
        s_byte_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (s_frame_start) begin
                    len_n     = (s_frame_len > MAX_LEN_B) ? MAX_LEN_B : s_frame_len;
                    chk_n     = '0;
                    cnt_n     = '0;
                    load      = 1'b1;
                    load_data = HDR0;
                    state_n   = S_HDR0;
                end
            end
            S_HDR0: begin
                if (ser_free) begin
                    load      = 1'b1;
                    load_data = HDR1;
                    state_n   = S_HDR1;
                end
            end
            S_HDR1: begin
                if (ser_free) begin
                    load      = 1'b1;
                    load_data = len_q;
                    chk_n     = chk_q + len_q;
                    state_n   = S_LEN;
                end
            end
            S_LEN, S_PAYLOAD: begin
                if (ser_free) begin
                    if (cnt_q != len_q) begin
                        s_byte_ready = 1'b1;
                        state_n      = S_PAYLOAD;
                        if (s_byte_valid) begin
                            load      = 1'b1;
                            load_data = s_byte_data;
                            chk_n     = chk_q + s_byte_data;
                            cnt_n     = cnt_q + 8'd1;
                        end
                    end else begin
                        load      = 1'b1;
                        load_data = chk_q;
                        state_n   = S_CHK;
                    end
                end
            end
`ifdef UART_FRAME_TAIL_EN
            S_CHK: begin
                if (ser_free) begin
                    load      = 1'b1;
                    load_data = 8'h0D;
                    state_n   = S_TAIL0;
                end
            end
            S_TAIL0: begin
                if (ser_free) begin
                    load      = 1'b1;
                    load_data = 8'h0A;
                    state_n   = S_TAIL1;
                end
            end
            S_TAIL1: begin
                if (ser_free) state_n = S_DONE;
            end
`else
            S_CHK: begin
                if (ser_free) state_n = S_DONE;
            end
`endif
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign m_busy       = (state != S_IDLE) && (state != S_DONE);
    assign m_frame_done = (state == S_DONE);

    // Shift register holds d0..d7 plus the stop bit; tx is registered so the line never glitches.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            tx         <= 1'b1;
            ser_active <= 1'b0;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            shreg      <= '0;
        end else if (load) begin
            tx         <= 1'b0;
            ser_active <= 1'b1;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            shreg      <= {1'b1, load_data};
        end else if (ser_active) begin
            if (baud_cnt == BW'(DIV - 1)) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    ser_active <= 1'b0;
                    bit_cnt    <= '0;
                    tx         <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end
        end
    end

endmodule
